// File: rtl/ifu_ift2icb_if.sv
// Bundle of the fetch request/response channel and the instruction ICB channel.
// The adapter connects through the slave modport; its environment uses master.
interface ifu_ift2icb_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_W-1:0]    ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;
  logic               ifu_rsp_err;
  logic [INSTR_W-1:0] ifu_rsp_instr;
  logic               icb_cmd_valid;
  logic               icb_cmd_ready;
  logic [PC_W-1:0]    icb_cmd_addr;
  logic               icb_cmd_read;
  logic               icb_rsp_valid;
  logic               icb_rsp_ready;
  logic               icb_rsp_err;
  logic [INSTR_W-1:0] icb_rsp_rdata;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr,
           icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_rsp_ready
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr,
           icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_rsp_ready
  );
endinterface

// File: rtl/ifu_ift2icb.sv
// Fetch-to-ICB read adapter with credit-bounded in-order response FIFO.
// Define E203_IFT_RSP_BYPASS_EN to pass a bus response straight through when the FIFO is empty.
module ifu_ift2icb #(
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int OTF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  ifu_ift2icb_if.slave bus
);
  localparam int CNT_W = $clog2(OTF_DEPTH + 1);
  localparam int PTR_W = (OTF_DEPTH > 1) ? $clog2(OTF_DEPTH) : 1;

  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   occ;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               fifo_err   [OTF_DEPTH];
  logic [INSTR_W-1:0] fifo_instr [OTF_DEPTH];

  logic [CNT_W:0]     credit;
  logic               room;
  logic               aligned;
  logic               cmd_hsk;
  logic               mis_hsk;
  logic               rsp_take;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               push_err;
  logic [INSTR_W-1:0] push_instr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OTF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign credit  = {1'b0, inflight} + {1'b0, occ};
  assign room    = credit < (CNT_W + 1)'(OTF_DEPTH);
  assign aligned = (bus.ifu_req_pc[1:0] == 2'b00);

  assign bus.icb_cmd_valid = bus.ifu_req_valid & aligned & room;
  assign bus.icb_cmd_addr  = {bus.ifu_req_pc[PC_W-1:2], 2'b00};
  assign bus.icb_cmd_read  = 1'b1;
  assign bus.icb_rsp_ready = 1'b1;

  // A misaligned fetch waits for the bus to drain so its local error stays in order.
  assign bus.ifu_req_ready = aligned ? (bus.icb_cmd_ready & room)
                                     : (room & (inflight == '0));

  assign cmd_hsk  = bus.ifu_req_valid & bus.ifu_req_ready & aligned;
  assign mis_hsk  = bus.ifu_req_valid & bus.ifu_req_ready & ~aligned;
  assign rsp_take = bus.icb_rsp_valid & (inflight != '0);

`ifdef E203_IFT_RSP_BYPASS_EN
  assign bypass = rsp_take & (occ == '0);
`else
  assign bypass = 1'b0;
`endif

  // mis_hsk needs inflight==0 and rsp_take needs inflight!=0, so one write port suffices.
  assign pop        = (occ != '0) & bus.ifu_rsp_ready;
  assign push       = mis_hsk | (rsp_take & ~(bypass & bus.ifu_rsp_ready));
  assign push_err   = mis_hsk | bus.icb_rsp_err;
  assign push_instr = mis_hsk ? '0 : bus.icb_rsp_rdata;

  assign bus.ifu_rsp_valid = (occ != '0) | bypass;
  assign bus.ifu_rsp_err   = bypass ? bus.icb_rsp_err   : fifo_err[rd_ptr];
  assign bus.ifu_rsp_instr = bypass ? bus.icb_rsp_rdata : fifo_instr[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight + CNT_W'(cmd_hsk) - CNT_W'(rsp_take);
      occ      <= occ + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OTF_DEPTH; i++) begin
        fifo_err[i]   <= 1'b0;
        fifo_instr[i] <= '0;
      end
    end else if (push) begin
      fifo_err[wr_ptr]   <= push_err;
      fifo_instr[wr_ptr] <= push_instr;
    end
  end
endmodule
